// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned BLOCK_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [BLOCK_W-1:0] block_t;

  typedef struct packed {
    addr_t  pc;
    block_t word;
  } inst_t;

  localparam block_t HALT_WORD = 16'hffff;
  localparam block_t NOP_WORD  = 16'h0000;

  typedef enum logic [1:0] {
    StRun,
    StRedirect,
    StDrain,
    StHalt
  } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: redirect requests and the fetch output in, PC and status out.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic  branch_valid;
  addr_t branch_target;
  logic  jump_valid;
  addr_t jump_target;
  logic  consumed_inst;
  inst_t fetched_inst;
  addr_t pc;
  logic  do_branch;
  logic  do_jump;
  logic  halted;
  logic  draining;

  modport master (
    input  branch_valid, branch_target, jump_valid, jump_target, consumed_inst, fetched_inst,
    output pc, do_branch, do_jump, halted, draining
  );

  modport slave (
    output branch_valid, branch_target, jump_valid, jump_target, consumed_inst, fetched_inst,
    input  pc, do_branch, do_jump, halted, draining
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: branch over jump over sequential/hold, plus halt detect.
module fetch_next_pc
  import fetch_sequencer_pkg::*;
(
  input  seq_state_t state_i,
  input  addr_t      pc_i,
  input  logic       branch_valid_i,
  input  addr_t      branch_target_i,
  input  logic       jump_valid_i,
  input  addr_t      jump_target_i,
  input  logic       consumed_i,
  input  block_t     word_i,
  output addr_t      pc_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic       halt_o
);

  always_comb begin
    pc_o     = pc_i;
    branch_o = 1'b0;
    jump_o   = 1'b0;
    halt_o   = 1'b0;
    unique case (state_i)
      StRun, StRedirect, StDrain: begin
        if (branch_valid_i) begin
          pc_o     = branch_target_i;
          branch_o = 1'b1;
        end else if (jump_valid_i) begin
          pc_o   = jump_target_i;
          jump_o = 1'b1;
        end else if (state_i != StDrain && consumed_i) begin
          // The word fetched right after a redirect is wrong-path, so it cannot halt us.
          if (state_i == StRun && word_i == HALT_WORD) begin
            halt_o = 1'b1;
          end else begin
            pc_o = pc_i + addr_t'(1);
          end
        end
      end
      StHalt: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: redirect strobes, halt detection, drain window and front-end freeze.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic                clk,
  input logic                rst,
  fetch_sequencer_if.master  seq_io
);

  localparam int unsigned CntW = 4;

  seq_state_t      state_q;
  addr_t           pc_q, pc_d;
  logic            do_branch_q, do_jump_q, halted_q, draining_q;
  logic [CntW-1:0] cnt_q;
  logic            take_branch, take_jump, halt_det, redirect;

  fetch_next_pc u_next_pc (
    .state_i         (state_q),
    .pc_i            (pc_q),
    .branch_valid_i  (seq_io.branch_valid),
    .branch_target_i (seq_io.branch_target),
    .jump_valid_i    (seq_io.jump_valid),
    .jump_target_i   (seq_io.jump_target),
    .consumed_i      (seq_io.consumed_inst),
    .word_i          (seq_io.fetched_inst.word),
    .pc_o            (pc_d),
    .branch_o        (take_branch),
    .jump_o          (take_jump),
    .halt_o          (halt_det)
  );

  assign redirect = take_branch | take_jump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      pc_q        <= '0;
      do_branch_q <= 1'b0;
      do_jump_q   <= 1'b0;
      halted_q    <= 1'b0;
      draining_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      do_branch_q <= take_branch;
      do_jump_q   <= take_jump;
      unique case (state_q)
        StRun: begin
          if (redirect) begin
            state_q <= StRedirect;
          end else if (halt_det) begin
            state_q    <= StDrain;
            draining_q <= 1'b1;
            cnt_q      <= CntW'(DRAIN_CYCLES - 1);
          end
        end
        StRedirect: state_q <= redirect ? StRedirect : StRun;
        StDrain: begin
          // An older redirect arriving in the window means the halt was on a wrong path.
          if (redirect) begin
            state_q    <= StRedirect;
            draining_q <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q    <= StHalt;
            draining_q <= 1'b0;
            halted_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHalt: ;
        default: state_q <= StRun;
      endcase
    end
  end

  assign seq_io.pc        = pc_q;
  assign seq_io.do_branch = do_branch_q;
  assign seq_io.do_jump   = do_jump_q;
  assign seq_io.halted    = halted_q;
  assign seq_io.draining  = draining_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then randomized traffic.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int unsigned Drain = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .DRAIN_CYCLES (Drain)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_io (bus.master)
  );

  typedef struct {
    addr_t pc;
    logic  br;
    logic  jp;
    logic  halted;
    logic  draining;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: what the front end should be showing after each clock.
  addr_t m_pc;
  logic  m_br, m_jp, m_halted, m_drain;
  int    m_left;

  function automatic void m_reset();
    m_pc = '0; m_br = 0; m_jp = 0; m_halted = 0; m_drain = 0; m_left = 0;
  endfunction

  function automatic void m_step(logic b, addr_t bt, logic j, addr_t jt, logic c, block_t w);
    logic after_redirect;
    if (m_halted) return;
    after_redirect = m_br || m_jp;
    if (b) begin
      m_pc = bt; m_br = 1; m_jp = 0; m_drain = 0;
    end else if (j) begin
      m_pc = jt; m_br = 0; m_jp = 1; m_drain = 0;
    end else begin
      m_br = 0; m_jp = 0;
      if (m_drain) begin
        if (m_left == 0) begin
          m_drain = 0; m_halted = 1;
        end else begin
          m_left = m_left - 1;
        end
      end else if (c && w == HALT_WORD && !after_redirect) begin
        m_drain = 1; m_left = Drain - 1;
      end else if (c) begin
        m_pc = addr_t'((int'(m_pc) + 1) % 512);
      end
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc; e.br = m_br; e.jp = m_jp; e.halted = m_halted; e.draining = m_drain;
    return e;
  endfunction

  function automatic void compare(exp_t e, string tag);
    n_vec++;
    if (bus.pc !== e.pc || bus.do_branch !== e.br || bus.do_jump !== e.jp ||
        bus.halted !== e.halted || bus.draining !== e.draining) begin
      n_err++;
      $display("FAIL %s t=%0t got pc=%0d br=%b jp=%b hlt=%b drn=%b want pc=%0d br=%b jp=%b hlt=%b drn=%b",
               tag, $time, bus.pc, bus.do_branch, bus.do_jump, bus.halted, bus.draining,
               e.pc, e.br, e.jp, e.halted, e.draining);
    end
  endfunction

  task automatic drive(logic b, addr_t bt, logic j, addr_t jt, logic c, block_t w);
    @(negedge clk);
    rst = 1'b1;
    bus.branch_valid  = b;
    bus.branch_target = bt;
    bus.jump_valid    = j;
    bus.jump_target   = jt;
    bus.consumed_inst = c;
    bus.fetched_inst  = '{pc: m_pc, word: w};
    m_step(b, bt, j, jt, c, w);
    exp_q.push_back(snap());
  endtask

  task automatic idle(logic c, block_t w);
    drive(1'b0, '0, 1'b0, '0, c, w);
  endtask

  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    m_reset();
    #1 compare(snap(), tag);
  endtask

  // Monitor: one expected entry per clock that was driven out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e, "scb");
      end
    end
  end

  initial begin
    int halt_cycles;
    logic b, j, c;
    addr_t bt, jt;
    block_t w;

    bus.branch_valid = 0; bus.branch_target = '0; bus.jump_valid = 0; bus.jump_target = '0;
    bus.consumed_inst = 0; bus.fetched_inst = '0;
    m_reset();
    #1 compare(snap(), "reset");

    // Sequential fetch from 0
    repeat (5) idle(1'b1, NOP_WORD);

    // Stall at pc=2
    async_reset("rst_t2");
    repeat (2) idle(1'b1, NOP_WORD);
    repeat (3) idle(1'b0, NOP_WORD);
    idle(1'b1, NOP_WORD);

    // Branch beats simultaneous jump
    drive(1'b1, addr_t'(9), 1'b1, addr_t'(20), 1'b0, NOP_WORD);
    idle(1'b0, NOP_WORD);
    idle(1'b1, NOP_WORD);

    // Halt at pc=5, drain, freeze, jump ignored
    async_reset("rst_t4");
    repeat (5) idle(1'b1, NOP_WORD);
    idle(1'b1, HALT_WORD);
    repeat (3) idle(1'b1, NOP_WORD);
    drive(1'b0, '0, 1'b1, addr_t'(33), 1'b1, NOP_WORD);
    idle(1'b1, NOP_WORD);

    // Branch on 2nd drain cycle cancels the halt
    async_reset("rst_t5");
    repeat (5) idle(1'b1, NOP_WORD);
    idle(1'b1, HALT_WORD);
    idle(1'b1, NOP_WORD);
    drive(1'b1, addr_t'(1), 1'b0, '0, 1'b0, NOP_WORD);
    repeat (5) idle(1'b1, NOP_WORD);

    // Halt word right after a redirect is discarded
    drive(1'b0, '0, 1'b1, addr_t'(100), 1'b0, NOP_WORD);
    idle(1'b1, HALT_WORD);
    idle(1'b1, NOP_WORD);

    // Wrap 511 -> 0, then reset during drain
    drive(1'b0, '0, 1'b1, addr_t'(511), 1'b1, NOP_WORD);
    idle(1'b1, NOP_WORD);
    idle(1'b1, NOP_WORD);
    idle(1'b1, HALT_WORD);
    idle(1'b1, NOP_WORD);
    async_reset("rst_drain");
    idle(1'b1, NOP_WORD);

    // Randomized traffic
    halt_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (halt_cycles > 4 || $urandom_range(0, 99) == 0) begin
        async_reset("rst_rand");
        halt_cycles = 0;
      end
      b  = ($urandom_range(0, 99) < 12);
      j  = ($urandom_range(0, 99) < 15);
      c  = ($urandom_range(0, 99) < 75);
      bt = ($urandom_range(0, 9) == 0) ? addr_t'(511) : addr_t'($urandom_range(0, 511));
      jt = ($urandom_range(0, 9) == 0) ? addr_t'(511) : addr_t'($urandom_range(0, 511));
      w  = ($urandom_range(0, 99) < 25) ? HALT_WORD : block_t'($urandom_range(0, 65535));
      drive(b, bt, j, jt, c, w);
      if (m_halted) halt_cycles++;
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_q left=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
